// File: rtl/sn_io_pkg.sv
// rtl/sn_io_pkg.sv - shared types and constants for the sn_io UART register-access host
package sn_io_pkg;

    typedef struct packed {
        logic       r0w1;
        logic [6:0] addr;
    } sn_io_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_DATA,
        RX_WAIT,
        DONE
    } sn_io_host_state_t;

    localparam logic SN_IO_READ      = 1'b0;
    localparam logic SN_IO_WRITE     = 1'b1;
    localparam logic SN_IO_LINE_IDLE = 1'b1;

    // Bits needed to hold 0 .. max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/sn_io_protocol_host_if.sv
// rtl/sn_io_protocol_host_if.sv - request/response bundle between a requester and the sn_io host
interface sn_io_protocol_host_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_r0w1;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic       busy;

    modport master (
        output req_valid, req_r0w1, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
    );

    modport slave (
        input  req_valid, req_r0w1, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
    );
endinterface

// File: rtl/sn_io_uart_byte.sv
// rtl/sn_io_uart_byte.sv - 8N1 byte serialiser and mid-bit sampling deserialiser
module sn_io_uart_byte
    import sn_io_pkg::*;
#(
    parameter int P_CLKS_PER_BIT    = 87,
    parameter int P_BITS_TO_SEND    = 10,
    parameter int P_BITS_TO_RECEIVE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx_en,
    input  logic       rx_in,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int CW  = cnt_width(P_CLKS_PER_BIT);
    localparam int TBW = cnt_width(P_BITS_TO_SEND);
    localparam int RBW = cnt_width(P_BITS_TO_RECEIVE);
    localparam int TSW = P_BITS_TO_SEND - 1;
    localparam logic [CW-1:0]  BIT_LAST = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  BIT_MID  = CW'(P_CLKS_PER_BIT / 2);
    localparam logic [TBW-1:0] TX_LAST  = TBW'(P_BITS_TO_SEND - 1);
    localparam logic [RBW-1:0] RX_LAST  = RBW'(P_BITS_TO_RECEIVE - 1);

    logic           tx_busy;
    logic [CW-1:0]  tx_cnt;
    logic [TBW-1:0] tx_bit;
    logic [TSW-1:0] tx_shift;

    // A tx_start in the same cycle as tx_done chains the next frame with no idle gap.
    assign tx_done = tx_busy && (tx_cnt == BIT_LAST) && (tx_bit == TX_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx       <= SN_IO_LINE_IDLE;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else if (tx_start) begin
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= {{(TSW-8){1'b1}}, tx_data};
        end else if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == TX_LAST) begin
                    tx_busy <= 1'b0;
                    tx      <= SN_IO_LINE_IDLE;
                end else begin
                    tx_bit   <= tx_bit + 1'b1;
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[TSW-1:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    logic           rx_prev;
    logic           rx_busy;
    logic [CW-1:0]  rx_cnt;
    logic [RBW-1:0] rx_bit;
    logic [7:0]     rx_shift;

    // The edge-detect cycle counts as offset 0, so the start bit is re-read at offset P/2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_prev  <= SN_IO_LINE_IDLE;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_prev  <= rx_in;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_en) begin
                rx_busy <= 1'b0;
            end else if (!rx_busy) begin
                if (rx_prev && !rx_in) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= CW'(1);
                    rx_bit  <= '0;
                end
            end else if ((rx_bit == '0) ? (rx_cnt == BIT_MID) : (rx_cnt == BIT_LAST)) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == '0) begin
                    if (rx_in) rx_busy <= 1'b0;
                end else if (rx_bit == RX_LAST) begin
                    rx_busy <= 1'b0;
                    if (rx_in) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_shift;
                    end else begin
                        rx_ferr <= 1'b1;
                    end
                end else begin
                    rx_shift <= {rx_in, rx_shift[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sn_io_protocol_host.sv
// rtl/sn_io_protocol_host.sv - sn_io UART register-access host (FSM + watchdog); optional SN_IO_HOST_RX_SYNC_EN
module sn_io_protocol_host
    import sn_io_pkg::*;
#(
    parameter int P_CLKS_PER_BIT       = 87,
    parameter int P_BITS_TO_SEND       = 10,
    parameter int P_BITS_TO_RECEIVE    = 10,
    parameter int P_PROT_WATCHDOG_TIME = 100000000
) (
    input  logic                 clk,
    input  logic                 rst,
    sn_io_protocol_host_if.slave bus,
    output logic                 uart_tx,
    input  logic                 uart_rx
);

    localparam int WW = cnt_width(P_PROT_WATCHDOG_TIME);
    localparam logic [WW-1:0] WD_LAST = WW'(P_PROT_WATCHDOG_TIME - 1);

    sn_io_host_state_t state_q, state_d;
    logic       r0w1_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       timeout_q;
    logic [WW-1:0] wd_cnt;

    sn_io_cmd_t cmd;
    logic       tx_start, tx_done;
    logic [7:0] tx_byte;
    logic       rx_line, rx_valid, rx_ferr, rx_good;
    logic [7:0] rx_data;
    logic       wd_expired;

`ifdef SN_IO_HOST_RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk) begin
        if (!rst) rx_sync <= 2'b11;
        else      rx_sync <= {rx_sync[0], uart_rx};
    end
    assign rx_line = rx_sync[1];
`else
    assign rx_line = uart_rx;
`endif

    assign cmd        = {bus.req_r0w1, bus.req_addr};
    assign rx_good    = rx_valid && !rx_ferr;
    assign wd_expired = (wd_cnt == WD_LAST);

    sn_io_uart_byte #(
        .P_CLKS_PER_BIT   (P_CLKS_PER_BIT),
        .P_BITS_TO_SEND   (P_BITS_TO_SEND),
        .P_BITS_TO_RECEIVE(P_BITS_TO_RECEIVE)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_byte),
        .tx_done (tx_done),
        .tx      (uart_tx),
        .rx_en   (state_q == RX_WAIT),
        .rx_in   (rx_line),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr)
    );

    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        tx_byte  = wdata_q;
        case (state_q)
            IDLE: begin
                tx_byte = cmd;
                if (bus.req_valid) begin
                    tx_start = 1'b1;
                    state_d  = TX_CMD;
                end
            end
            TX_CMD: begin
                if (tx_done) begin
                    if (r0w1_q == SN_IO_WRITE) begin
                        tx_start = 1'b1;
                        state_d  = TX_DATA;
                    end else begin
                        state_d = RX_WAIT;
                    end
                end
            end
            TX_DATA: if (tx_done) state_d = DONE;
            // A good byte landing on the last watchdog cycle still counts as a reply.
            RX_WAIT: if (rx_good || wd_expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            r0w1_q    <= SN_IO_READ;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            state_q <= state_d;
            wd_cnt  <= (state_q == RX_WAIT) ? wd_cnt + 1'b1 : '0;
            if (state_q == IDLE && bus.req_valid) begin
                r0w1_q  <= bus.req_r0w1;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == TX_DATA && state_d == DONE) begin
                rdata_q   <= '0;
                timeout_q <= 1'b0;
            end
            if (state_q == RX_WAIT && state_d == DONE) begin
                rdata_q   <= rx_good ? rx_data : 8'h00;
                timeout_q <= !rx_good;
            end
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.rsp_valid   = (state_q == DONE);
    assign bus.rsp_timeout = (state_q == DONE) && timeout_q;
    assign bus.rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_sn_io_protocol_host.sv
// tb/tb_sn_io_protocol_host.sv - directed bench with a responder BFM for sn_io_protocol_host
module tb_sn_io_protocol_host;

    localparam int P  = 8;
    localparam int WD = 2000;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    sn_io_protocol_host_if bus ();

    sn_io_protocol_host #(
        .P_CLKS_PER_BIT      (P),
        .P_BITS_TO_SEND      (10),
        .P_BITS_TO_RECEIVE   (10),
        .P_PROT_WATCHDOG_TIME(WD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic capture_tx(output logic [7:0] b, output int t0, output bit ok);
        int w;
        w  = 0;
        ok = 1'b1;
        b  = 8'h00;
        do begin
            @(negedge clk);
            w++;
        end while (uart_tx !== 1'b0 && w < 3000);
        t0 = cyc;
        if (uart_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (P/2) @(negedge clk);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (P) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (P) @(negedge clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (P) @(negedge clk);
        end
        uart_rx = stop;
        repeat (P/2 + 1) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic issue(input logic r0w1, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.req_r0w1  = r0w1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready got %b want 1", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n, output int ready_hi);
        n        = 0;
        ready_hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.req_ready === 1'b1) ready_hi++;
        end while (bus.rsp_valid !== 1'b1 && n < 6000);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({uart_tx, bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata} !== 13'b1_1_0_0_0_00000000) begin
            errors++;
            $display("FAIL reset_state got %b want 1100000000000",
                     {uart_tx, bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata});
        end
        rst = 1'b1;
    endtask

    task automatic test_write();
        logic [7:0] b0, b1;
        int t0, t1, n, rh;
        bit ok0, ok1;
        issue(1'b1, 7'h05, 8'hA5);
        fork
            begin
                capture_tx(b0, t0, ok0);
                capture_tx(b1, t1, ok1);
            end
            wait_rsp(n, rh);
        join
        checks++;
        if (!(ok0 && ok1) || b0 !== 8'h85) begin
            errors++;
            $display("FAIL write_cmd_frame got %h ok %b want 85 ok 1", b0, ok0);
        end
        checks++;
        if (!ok1 || b1 !== 8'hA5) begin
            errors++;
            $display("FAIL write_data_frame got %h ok %b want a5 ok 1", b1, ok1);
        end
        checks++;
        if (t1 - t0 !== 10*P) begin
            errors++;
            $display("FAIL write_no_gap got %0d want %0d", t1 - t0, 10*P);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || n !== 161) begin
            errors++;
            $display("FAIL write_latency got %0d want 161", n);
        end
        checks++;
        if (bus.rsp_rdata !== 8'h00 || bus.rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp got rdata %h to %b want 00 0", bus.rsp_rdata, bus.rsp_timeout);
        end
    endtask

    task automatic test_read();
        logic [7:0] b0;
        int t0, n, rh;
        bit ok0;
        issue(1'b0, 7'h12, 8'h00);
        fork
            begin
                capture_tx(b0, t0, ok0);
                repeat (50) @(negedge clk);
                send_rx(8'hF1, 1'b1);
            end
            wait_rsp(n, rh);
        join
        checks++;
        if (!ok0 || b0 !== 8'h12) begin
            errors++;
            $display("FAIL read_cmd_frame got %h ok %b want 12 ok 1", b0, ok0);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'hF1 || bus.rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp got v %b rdata %h to %b want 1 f1 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b0;
        int t0, n, rh;
        bit ok0;
        issue(1'b0, 7'h2A, 8'h00);
        fork
            capture_tx(b0, t0, ok0);
            wait_rsp(n, rh);
        join
        checks++;
        if (bus.rsp_valid !== 1'b1 || n !== 10*P + WD + 1) begin
            errors++;
            $display("FAIL timeout_latency got %0d want %0d", n, 10*P + WD + 1);
        end
        checks++;
        if (bus.rsp_timeout !== 1'b1 || bus.rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL timeout_rsp got to %b rdata %h want 1 00", bus.rsp_timeout, bus.rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_timeout !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse got to %b v %b rdy %b want 0 0 1",
                     bus.rsp_timeout, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_framing();
        logic [7:0] b0;
        int t0, n, rh;
        bit ok0;
        issue(1'b0, 7'h40, 8'h00);
        fork
            begin
                capture_tx(b0, t0, ok0);
                repeat (10) @(negedge clk);
                uart_rx = 1'b0;
                repeat (2) @(negedge clk);
                uart_rx = 1'b1;
                repeat (12) @(negedge clk);
                send_rx(8'h33, 1'b0);
                repeat (4) @(negedge clk);
                send_rx(8'hF4, 1'b1);
            end
            wait_rsp(n, rh);
        join
        checks++;
        if (!ok0 || b0 !== 8'h40) begin
            errors++;
            $display("FAIL ferr_cmd_frame got %h ok %b want 40 ok 1", b0, ok0);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'hF4 || bus.rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL ferr_rsp got v %b rdata %h to %b want 1 f4 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b0;
        int t0, n, rh;
        bit ok0;
        issue(1'b0, 7'h55, 8'h00);
        repeat (4*P + 3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_bit3 got tx %b busy %b want 0 1", uart_tx, bus.busy);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame got tx %b rdy %b busy %b want 1 1 0",
                     uart_tx, bus.req_ready, bus.busy);
        end
        rst = 1'b1;
        issue(1'b0, 7'h01, 8'h00);
        fork
            begin
                capture_tx(b0, t0, ok0);
                repeat (20) @(negedge clk);
                send_rx(8'h5A, 1'b1);
            end
            wait_rsp(n, rh);
        join
        checks++;
        if (!ok0 || b0 !== 8'h01) begin
            errors++;
            $display("FAIL post_reset_cmd got %h ok %b want 01 ok 1", b0, ok0);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h5A || bus.rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rsp got v %b rdata %h to %b want 1 5a 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.req_r0w1  = 1'b0;
        bus.req_addr  = 7'h33;
        bus.req_wdata = 8'h00;
        bus.req_valid = 1'b1;
        fork
            begin
                logic [7:0] b0, v;
                int t0;
                bit ok0;
                for (int i = 0; i < 4; i++) begin
                    capture_tx(b0, t0, ok0);
                    checks++;
                    if (!ok0 || b0 !== 8'h33) begin
                        errors++;
                        $display("FAIL b2b_cmd_%0d got %h ok %b want 33 ok 1", i, b0, ok0);
                    end
                    v = 8'(8'hF1 + i);
                    repeat (10) @(negedge clk);
                    send_rx(v, 1'b1);
                end
            end
            begin
                int n, rh;
                logic [7:0] exp_d;
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk);
                    #1;
                    wait_rsp(n, rh);
                    exp_d = 8'(8'hF1 + i);
                    checks++;
                    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_d || rh !== 0) begin
                        errors++;
                        $display("FAIL b2b_rsp_%0d got v %b rdata %h ready_hi %0d want 1 %h 0",
                                 i, bus.rsp_valid, bus.rsp_rdata, rh, exp_d);
                    end
                    if (i == 3) bus.req_valid = 1'b0;
                    @(negedge clk);
                    checks++;
                    if (bus.req_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_idle_%0d got rdy %b want 1", i, bus.req_ready);
                    end
                end
            end
        join
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final_busy got %b want 0", bus.busy);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_r0w1  = 1'b0;
        bus.req_addr  = 7'h00;
        bus.req_wdata = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_framing();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
